// File: rtl/seq_counter_ctrl.sv
// rtl/seq_counter_ctrl.sv - programmable table-driven sequence counter with start/stop/hold and loop count
module seq_counter_ctrl #(
   parameter int WIDTH  = 3,
   parameter int IDX_W  = 3,
   parameter int LOOP_W = 4
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              cfg_we,
   input  logic [IDX_W-1:0]  cfg_addr,
   input  logic [WIDTH-1:0]  cfg_data,
   input  logic              cfg_len_we,
   input  logic [IDX_W-1:0]  cfg_len,
   input  logic              start,
   input  logic              stop,
   input  logic              hold,
   input  logic [LOOP_W-1:0] loops,
   output logic [WIDTH-1:0]  count,
   output logic [IDX_W-1:0]  index,
   output logic              busy,
   output logic              wrap,
   output logic              done,
   output logic              cfg_err
);

   localparam int DEPTH = 2 ** IDX_W;

   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

   state_t            state, state_n;
   logic [WIDTH-1:0]  tbl [DEPTH];
   logic [IDX_W-1:0]  len_m1;
   logic [LOOP_W-1:0] rem, rem_n;
   logic [WIDTH-1:0]  count_n;
   logic [IDX_W-1:0]  index_n, index_inc;
   logic              wrap_n, done_n, cfg_err_n;
   logic              cfg_any, start_ok, step, last, last_loop;

   // Reset-default table reproduces the legacy 0,3,5,6 sequence.
   function automatic logic [WIDTH-1:0] dflt(input int i);
      case (i)
         1:       dflt = WIDTH'(3);
         2:       dflt = WIDTH'(5);
         3:       dflt = WIDTH'(6);
         default: dflt = '0;
      endcase
   endfunction

   assign cfg_any   = cfg_we | cfg_len_we;
   assign start_ok  = start & ~stop & ~cfg_any;
   assign step      = (state == RUN) & ~stop & ~hold;
   assign last      = (index == len_m1);
   assign last_loop = (rem == LOOP_W'(1));
   assign index_inc = index + IDX_W'(1);

   always_ff @(negedge CLK) begin
      if (RESET) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start_ok) state_n = RUN;
         RUN: begin
            if (stop)                          state_n = IDLE;
            else if (hold)                     state_n = PAUSE;
            else if (last && last_loop)        state_n = IDLE;
         end
         PAUSE: begin
            if (stop)       state_n = IDLE;
            else if (!hold) state_n = RUN;
         end
         default: state_n = IDLE;
      endcase
   end

   // rem == 0 means a continuous run; it is never decremented below 1.
   always_comb begin
      count_n   = count;
      index_n   = index;
      rem_n     = rem;
      wrap_n    = 1'b0;
      done_n    = 1'b0;
      cfg_err_n = (state != IDLE) & cfg_any;
      if (state == IDLE && start_ok) begin
         index_n = '0;
         count_n = tbl[0];
         rem_n   = loops;
      end else if (step) begin
         if (last) begin
            index_n = '0;
            count_n = tbl[0];
            wrap_n  = 1'b1;
            if (last_loop)            done_n = 1'b1;
            else if (rem != '0)       rem_n  = rem - LOOP_W'(1);
         end else begin
            index_n = index_inc;
            count_n = tbl[index_inc];
         end
      end
   end

   always_ff @(negedge CLK) begin
      if (RESET) begin
         count   <= '0;
         index   <= '0;
         rem     <= '0;
         busy    <= 1'b0;
         wrap    <= 1'b0;
         done    <= 1'b0;
         cfg_err <= 1'b0;
         len_m1  <= IDX_W'(3);
         for (int i = 0; i < DEPTH; i++) tbl[i] <= dflt(i);
      end else begin
         count   <= count_n;
         index   <= index_n;
         rem     <= rem_n;
         busy    <= (state_n != IDLE);
         wrap    <= wrap_n;
         done    <= done_n;
         cfg_err <= cfg_err_n;
         if (state == IDLE) begin
            if (cfg_we)     tbl[cfg_addr] <= cfg_data;
            if (cfg_len_we) len_m1        <= cfg_len;
         end
      end
   end

endmodule

// File: tb/tb_seq_counter_ctrl.sv
// tb/tb_seq_counter_ctrl.sv - directed bench for seq_counter_ctrl with step-count reference model
module tb_seq_counter_ctrl;
   localparam int WIDTH  = 3;
   localparam int IDX_W  = 3;
   localparam int LOOP_W = 4;

   logic              CLK = 1'b0;
   logic              RESET = 1'b1;
   logic              cfg_we = 1'b0, cfg_len_we = 1'b0;
   logic [IDX_W-1:0]  cfg_addr = '0, cfg_len = '0;
   logic [WIDTH-1:0]  cfg_data = '0;
   logic              start = 1'b0, stop = 1'b0, hold = 1'b0;
   logic [LOOP_W-1:0] loops = '0;
   logic [WIDTH-1:0]  count;
   logic [IDX_W-1:0]  index;
   logic              busy, wrap, done, cfg_err;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   seq_counter_ctrl #(.WIDTH(WIDTH), .IDX_W(IDX_W), .LOOP_W(LOOP_W)) dut (
      .CLK(CLK), .RESET(RESET),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .cfg_len_we(cfg_len_we), .cfg_len(cfg_len),
      .start(start), .stop(stop), .hold(hold), .loops(loops),
      .count(count), .index(index), .busy(busy), .wrap(wrap), .done(done), .cfg_err(cfg_err)
   );

   always #5 CLK = ~CLK;

   // Reference: a run is a step counter k; position = k mod length, finite run ends at loops*length steps.
   int mt[8];
   int m_len, m_mode, m_k, m_loops, m_count, m_index;
   bit m_busy, m_wrap, m_done, m_err;

   task automatic m_reset();
      for (int i = 0; i < 8; i++) mt[i] = 0;
      mt[1] = 3; mt[2] = 5; mt[3] = 6;
      m_len = 3; m_mode = 0; m_k = 0; m_loops = 0; m_count = 0; m_index = 0;
   endtask

   always @(negedge CLK) begin
      m_wrap = 1'b0; m_done = 1'b0; m_err = 1'b0;
      if (RESET) m_reset();
      else if (m_mode == 0) begin
         if (cfg_we)     mt[cfg_addr] = int'(cfg_data);
         if (cfg_len_we) m_len = int'(cfg_len);
         if (start && !stop && !cfg_we && !cfg_len_we) begin
            m_mode = 1; m_k = 0; m_loops = int'(loops); m_index = 0; m_count = mt[0];
         end
      end else begin
         m_err = cfg_we | cfg_len_we;
         if (stop) m_mode = 0;
         else if (m_mode == 2) begin
            if (!hold) m_mode = 1;
         end else if (hold) m_mode = 2;
         else begin
            m_k++;
            m_index = m_k % (m_len + 1);
            m_count = mt[m_index];
            m_wrap  = (m_index == 0);
            if (m_loops != 0 && m_k == m_loops * (m_len + 1)) begin
               m_done = 1'b1;
               m_mode = 0;
            end
         end
      end
      m_busy = (m_mode != 0);
   end

   always @(posedge CLK) begin
      if (chk_en) begin
         checks++;
         if (count !== WIDTH'(m_count) || index !== IDX_W'(m_index) || busy !== m_busy ||
             wrap !== m_wrap || done !== m_done || cfg_err !== m_err) begin
            errors++;
            $display("FAIL model t=%0t: count=%0d index=%0d busy=%b wrap=%b done=%b cfg_err=%b, expected %0d %0d %b %b %b %b",
                     $time, count, index, busy, wrap, done, cfg_err,
                     m_count, m_index, m_busy, m_wrap, m_done, m_err);
         end
      end
   end

   task automatic cyc();
      @(negedge CLK);
      #1;
   endtask

   task automatic expect_out(input string nm, input int c, input bit b, input bit w, input bit d, input bit e);
      checks++;
      if (count !== WIDTH'(c) || busy !== b || wrap !== w || done !== d || cfg_err !== e) begin
         errors++;
         $display("FAIL %s: count=%0d busy=%b wrap=%b done=%b cfg_err=%b, expected count=%0d busy=%b wrap=%b done=%b cfg_err=%b",
                  nm, count, busy, wrap, done, cfg_err, c, b, w, d, e);
      end
   endtask

   task automatic expect_index(input string nm, input int i);
      checks++;
      if (index !== IDX_W'(i)) begin
         errors++;
         $display("FAIL %s: index=%0d expected %0d", nm, index, i);
      end
   endtask

   task automatic run_seq(input string nm, input int exp[8], input int n, input int wrapv);
      for (int i = 0; i < n; i++) begin
         cyc();
         expect_out(nm, exp[i], 1'b1, exp[i] == wrapv, 1'b0, 1'b0);
      end
   endtask

   task automatic do_start(input string nm, input int lp, input int first);
      loops = LOOP_W'(lp); start = 1'b1;
      cyc();
      start = 1'b0;
      expect_out(nm, first, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      cyc();
      chk_en = 1'b1;
      cyc();
      expect_out("reset", 0, 0, 0, 0, 0);
      expect_index("reset index", 0);
      RESET = 1'b0;

      do_start("t1 start", 0, 0);
      run_seq("t1 cont", '{3, 5, 6, 0, 3, 5, 6, 0}, 8, 0);
      stop = 1'b1; cyc(); stop = 1'b0;
      expect_out("t1 stop", 0, 0, 0, 0, 0);

      start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
      expect_out("start with stop", 0, 0, 0, 0, 0);

      do_start("t2 start", 2, 0);
      run_seq("t2 loops", '{3, 5, 6, 0, 3, 5, 6, 0}, 7, 0);
      cyc();
      expect_out("t2 done", 0, 0, 1, 1, 0);
      cyc();
      expect_out("t2 idle", 0, 0, 0, 0, 0);

      cfg_len_we = 1'b1; cfg_len = 3'd2; cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 3'd7;
      cyc();
      cfg_len_we = 1'b0; cfg_addr = 3'd1; cfg_data = 3'd1;
      cyc();
      cfg_addr = 3'd2; cfg_data = 3'd4; start = 1'b1;
      cyc();
      cfg_we = 1'b0; start = 1'b0;
      expect_out("start with cfg", 0, 0, 0, 0, 0);
      do_start("t3 start", 0, 7);
      run_seq("t3 len3", '{1, 4, 7, 1, 4, 7, 0, 0}, 6, 7);
      RESET = 1'b1; cyc(); RESET = 1'b0;
      expect_out("t3 reset", 0, 0, 0, 0, 0);

      do_start("t4 start", 0, 0);
      run_seq("t4 pre", '{3, 5, 0, 0, 0, 0, 0, 0}, 2, 0);
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         expect_out("t4 hold", 5, 1, 0, 0, 0);
      end
      hold = 1'b0; cyc();
      expect_out("t4 resume", 5, 1, 0, 0, 0);
      run_seq("t4 post", '{6, 0, 0, 0, 0, 0, 0, 0}, 2, 0);

      cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = 3'd2; cyc(); cfg_we = 1'b0;
      expect_out("t5 cfg_err", 3, 1, 0, 0, 1);
      run_seq("t5 after", '{5, 0, 0, 0, 0, 0, 0, 0}, 1, 0);
      stop = 1'b1; cyc(); stop = 1'b0;
      expect_out("t5 stop", 5, 0, 0, 0, 0);
      expect_index("t5 stop index", 2);
      cyc();
      expect_out("t5 idle hold", 5, 0, 0, 0, 0);
      do_start("t5 restart", 0, 0);
      run_seq("t5 table kept", '{3, 0, 0, 0, 0, 0, 0, 0}, 1, 0);
      stop = 1'b1; cyc(); stop = 1'b0;

      cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = 3'd7; cyc(); cfg_we = 1'b0;
      do_start("t6 start", 0, 0);
      run_seq("t6 reprog", '{7, 5, 6, 0, 0, 0, 0, 0}, 3, 0);
      RESET = 1'b1; cyc(); RESET = 1'b0;
      expect_out("t6 reset", 0, 0, 0, 0, 0);
      expect_index("t6 reset index", 0);
      do_start("t6 restart", 0, 0);
      run_seq("t6 default", '{3, 5, 6, 0, 0, 0, 0, 0}, 3, 0);

      hold = 1'b1; cyc();
      expect_out("pause", 6, 1, 0, 0, 0);
      start = 1'b1; cyc(); start = 1'b0;
      expect_out("pause start ignored", 6, 1, 0, 0, 0);
      stop = 1'b1; cyc(); stop = 1'b0; hold = 1'b0;
      expect_out("pause stop", 6, 0, 0, 0, 0);

      cfg_len_we = 1'b1; cfg_len = 3'd0; cyc(); cfg_len_we = 1'b0;
      do_start("len0 start", 3, 0);
      run_seq("len0 wraps", '{0, 0, 0, 0, 0, 0, 0, 0}, 2, 0);
      cyc();
      expect_out("len0 done", 0, 0, 1, 1, 0);
      cyc();
      cyc();

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/seq_counter_ctrl.md
Name: seq_counter_ctrl

Overview:
Programmable sequence-counter controller. Holds a small table of count values and steps through it on each active clock edge. Start, stop and hold commands control the stepping, and the block runs either continuously or for a fixed number of full sequences. It replaces hard-wired custom-sequence counters. The reset-default table produces 0,3,5,6,0, so existing users need no configuration.

Parameters:
WIDTH, 3, bit width of each count value
IDX_W, 3, index width; the table has DEPTH = 2**IDX_W entries
LOOP_W, 4, width of the loop-count input

Ports:
CLK  input  1  clock; all state updates on negedge CLK
RESET  input  1  synchronous, active-high reset, sampled on negedge CLK
cfg_we  input  1  write table entry cfg_addr with cfg_data
cfg_addr  input  IDX_W  table write address
cfg_data  input  WIDTH  table write data
cfg_len_we  input  1  write sequence length register len_m1 from cfg_len
cfg_len  input  IDX_W  sequence length minus 1
start  input  1  begin a run (IDLE only)
stop  input  1  abort a run
hold  input  1  pause stepping
loops  input  LOOP_W  full sequences to run; 0 = continuous; sampled at start
count  output  WIDTH  registered current count value
index  output  IDX_W  registered current table index
busy  output  1  registered; 1 when state is not IDLE
wrap  output  1  one-cycle pulse when the sequence returns to index 0 after the last entry
done  output  1  one-cycle pulse when a finite run completes
cfg_err  output  1  one-cycle pulse when a config write is rejected

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high (RESET). Every register updates only on negedge CLK.
- Reset values:
  - state = IDLE; count = 0; index = 0; busy/wrap/done/cfg_err = 0; loop counter rem = 0.
  - Table = {0,3,5,6} at entries 0..3; all other entries 0. len_m1 = 3.
- Reset mid-run: takes effect on that edge regardless of state. The table and len_m1 also return to their defaults.
- States: IDLE, RUN, PAUSE.
- Pulse outputs (wrap, done, cfg_err) default to 0 on every edge unless set below.
- IDLE:
  - cfg_we writes the table entry; cfg_len_we writes len_m1. Both may occur on the same edge. New values are visible from the next edge.
  - start=1, stop=0, cfg_we=0, cfg_len_we=0: go RUN; index=0; count=table[0]; rem=loops.
  - start together with stop, cfg_we or cfg_len_we: start ignored; any write is performed.
  - stop alone in IDLE: no effect.
- RUN, priority stop > hold > step:
  - stop: go IDLE; count and index hold their current values; no done pulse.
  - hold: go PAUSE; no advance on this edge.
  - step, index < len_m1: index+1; count = table[index+1].
  - step, index == len_m1: index=0; count=table[0]; wrap=1. Then:
    - loops==0 at start: continue running.
    - rem==1: done=1; go IDLE; count=table[0].
    - otherwise: rem -= 1.
- PAUSE:
  - stop: go IDLE; count and index held.
  - hold=0: go RUN; no advance on this edge, so resume costs one edge.
  - hold=1: stay in PAUSE; count and index held.
- In RUN or PAUSE, cfg_we or cfg_len_we: write discarded; cfg_err=1 for one cycle; the run continues normally.
- start in RUN or PAUSE: ignored.
- len_m1=0: single-entry sequence. wrap pulses every step; count stays at table[0].
- busy is registered and equals (next state != IDLE). It rises on the start edge and falls on the done or stop edge.

Test Plan:
1. RESET 2 edges; start, loops=0 → count 0,3,5,6,0,3,5,6,0…; wrap=1 on each edge where count goes 6→0; busy=1 throughout; done never asserts.
2. start, loops=2 → count 0,3,5,6,0,3,5,6,0. wrap on both 6→0 edges; done=1 together with the second wrap. busy drops on that same edge and count stays 0 in IDLE afterwards.
3. In IDLE: cfg_len=2 with table[0..2]=7,1,4, then start with loops=0 → count 7,1,4,7,1,4…; wrap on each 4→7 edge.
4. In RUN at count=5, hold=1 for 3 edges then release → count stays 5 during hold plus one extra edge (the resume edge), then continues 6,0.
5. In RUN, cfg_we addr=1 data=2 → cfg_err pulses once; sequence still 0,3,5,6. Then stop at count=5 → IDLE, count=5, busy=0, no done.
6. In RUN at count=6, assert RESET for one edge → count=0, index=0, busy=0. Restarting then yields 0,3,5,6 even if the table was reprogrammed before the reset.
